// File: rtl/ewrapper_io_rx_deser.sv
// 9-lane DDR receive deserializer: four CLK_IN cycles of even/odd lane bits form one registered 72-bit word.
// Define EWRAPPER_RX_FRAME_ALIGN_EN to align the word phase to rising edges on frame lane 8 (HUNT/LOCKED).
module ewrapper_io_rx_deser (
  input  logic        CLK_IN,
  input  logic        RESET_N,
  input  logic [8:0]  RX_EVEN,
  input  logic [8:0]  RX_ODD,
  output logic [71:0] DATA_OUT_TO_DEVICE,
  output logic        DATA_VALID,
  output logic        RX_LOCKED,
  output logic        ALIGN_ERR
);

  logic [1:0]      phase_q, phase_d;
  logic [1:0]      slot_sel;
  logic            slot_wr;
  logic            load_word;
  logic [2:0][8:0] even_slot_q;
  logic [2:0][8:0] odd_slot_q;
  logic [71:0]     data_q;
  logic [71:0]     word_asm;
  logic            valid_q;
  logic            locked_q, locked_d;
  logic            err_q, err_d;

  // Slots 0..2 come from storage; the phase-3 pair is taken straight from the inputs.
  always_comb begin
    word_asm = '0;
    for (int k = 0; k < 9; k++) begin
      word_asm[8*k+7] = even_slot_q[0][k];
      word_asm[8*k+6] = odd_slot_q[0][k];
      word_asm[8*k+5] = even_slot_q[1][k];
      word_asm[8*k+4] = odd_slot_q[1][k];
      word_asm[8*k+3] = even_slot_q[2][k];
      word_asm[8*k+2] = odd_slot_q[2][k];
      word_asm[8*k+1] = RX_EVEN[k];
      word_asm[8*k+0] = RX_ODD[k];
    end
  end

`ifdef EWRAPPER_RX_FRAME_ALIGN_EN
  typedef enum logic {HUNT, LOCKED} state_t;

  state_t state_q, state_d;
  logic   prev_frame_q;
  logic   frame_edge;

  assign frame_edge = ~prev_frame_q & RX_EVEN[8];

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    slot_sel  = phase_q;
    slot_wr   = 1'b0;
    load_word = 1'b0;
    err_d     = 1'b0;
    locked_d  = 1'b0;
    case (state_q)
      HUNT: begin
        phase_d = 2'd0;
        if (frame_edge) begin
          state_d  = LOCKED;
          slot_sel = 2'd0;
          slot_wr  = 1'b1;
          phase_d  = 2'd1;
        end
      end
      LOCKED: begin
        slot_wr = 1'b1;
        // A misplaced frame edge wins even at phase 3: the partial word is dropped and we restart at slot 0.
        if (frame_edge && (phase_q != 2'd0)) begin
          err_d    = 1'b1;
          slot_sel = 2'd0;
          phase_d  = 2'd1;
        end else begin
          phase_d   = phase_q + 2'd1;
          load_word = (phase_q == 2'd3);
        end
      end
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= HUNT;
      prev_frame_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_frame_q <= RX_ODD[8];
    end
  end
`else
  always_comb begin
    slot_sel  = phase_q;
    slot_wr   = 1'b1;
    phase_d   = phase_q + 2'd1;
    load_word = (phase_q == 2'd3);
    err_d     = 1'b0;
    locked_d  = 1'b1;
  end
`endif

  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      phase_q     <= 2'd0;
      even_slot_q <= '0;
      odd_slot_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (slot_wr && (slot_sel != 2'd3)) begin
        even_slot_q[slot_sel] <= RX_EVEN;
        odd_slot_q[slot_sel]  <= RX_ODD;
      end
      if (load_word) begin
        data_q <= word_asm;
      end
      valid_q  <= load_word;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign DATA_OUT_TO_DEVICE = data_q;
  assign DATA_VALID         = valid_q;
  assign RX_LOCKED          = locked_q;
  assign ALIGN_ERR          = err_q;

endmodule

// File: doc/ewrapper_io_rx_deser.md
EWRAPPER_IO_RX_DESER -- requirements
Module: ewrapper_io_rx_deser

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (9 lanes, 4 DDR cycles per word, 72-bit word).
REQ-002 CLK_IN  input  1  fast link clock; all sequential logic SHALL use its rising edge only.
REQ-003 RESET_N  input  1  asynchronous, active-low reset; one clock, no other reset.
REQ-004 RX_EVEN  input  9  per-lane bit captured on the link-clock rising edge, presented synchronous to CLK_IN; lane 8 is the frame lane.
REQ-005 RX_ODD  input  9  per-lane bit captured on the link-clock falling edge, presented in the same CLK_IN cycle as RX_EVEN.
REQ-006 DATA_OUT_TO_DEVICE  output  72  assembled word, registered.
REQ-007 DATA_VALID  output  1  one-cycle pulse marking a new DATA_OUT_TO_DEVICE word.
REQ-008 RX_LOCKED  output  1  word-phase alignment established.
REQ-009 ALIGN_ERR  output  1  one-cycle pulse on frame edge at an unexpected phase.

Function
REQ-010 A 2-bit phase counter (0..3) SHALL select the slot; each cycle stores RX_EVEN/RX_ODD for that slot.
REQ-011 Bit mapping for lane k (0..8), word bit base b=8k: phase 0 even->b+7, odd->b+6; phase 1 even->b+5, odd->b+4; phase 2 even->b+3, odd->b+2; phase 3 even->b+1, odd->b+0.
REQ-012 On the edge sampling phase 3, DATA_OUT_TO_DEVICE SHALL load the full word (three stored slots plus current inputs) and DATA_VALID SHALL be 1 for exactly the following cycle.
REQ-013 Latency: phase-0 sample at edge N -> word and DATA_VALID visible after edge N+3; DATA_VALID at most once per 4 cycles.
REQ-014 DATA_OUT_TO_DEVICE SHALL hold its value between DATA_VALID pulses.
REQ-015 Frame edge: registered previous-cycle RX_ODD[8]==0 and current RX_EVEN[8]==1; the current cycle is then phase 0.
REQ-016 Phase counter SHALL wrap 3->0 with no idle cycle.

Reset
REQ-017 While RESET_N==0: DATA_OUT_TO_DEVICE=0, DATA_VALID=0, RX_LOCKED=0, ALIGN_ERR=0, phase=0, slot storage=0, previous-frame bit=0, state=HUNT.
REQ-018 Reset assertion mid-word SHALL discard the partial word with no DATA_VALID; deassertion takes effect on the next CLK_IN rising edge.

Configuration
REQ-019 Macro EWRAPPER_RX_FRAME_ALIGN_EN SHALL select frame-based alignment.
REQ-020 Defined: states HUNT and LOCKED; in HUNT, DATA_VALID is suppressed, phase is ignored, RX_LOCKED=0.
REQ-021 Defined: HUNT->LOCKED on frame edge; that cycle is phase 0; RX_LOCKED=1 from the next cycle.
REQ-022 Defined, LOCKED: a frame edge at phase 0 keeps running.
REQ-023 Defined, LOCKED: a frame edge at phase 1-3 SHALL pulse ALIGN_ERR for one cycle, discard the partial word (no DATA_VALID), treat the cycle as phase 0 and stay LOCKED.
REQ-024 Defined: a frame edge in the same cycle as phase 3 SHALL take priority; no DATA_VALID, ALIGN_ERR=1.
REQ-025 Undefined: no state machine; phase free-runs from 0 on the first edge after reset release.
REQ-026 Undefined: RX_LOCKED=1 from that edge onward; ALIGN_ERR tied 0; RX_EVEN[8]/RX_ODD[8] are treated as data only.

Verification
REQ-027 Undefined macro, reset release, drive lane k even/odd so word=72'h0123456789ABCDEF01 -> DATA_VALID after edge 4 with exact word; repeat continuously -> pulses every 4 cycles.
REQ-028 Defined, RX_EVEN[8]=1 after 10 idle cycles, then 4 cycles of data -> RX_LOCKED rises next cycle, DATA_VALID exactly 4 cycles after frame edge, no DATA_VALID before.
REQ-029 Defined, LOCKED, frame edge injected at phase 2 -> ALIGN_ERR one cycle, partial word dropped, next word valid 4 cycles later with correct mapping.
REQ-030 Defined, frame edge coincident with phase 3 -> no DATA_VALID that cycle, ALIGN_ERR=1, realigned word follows.
REQ-031 RESET_N low at phase 2 mid-word -> all outputs 0 immediately (asynchronous), no DATA_VALID; after release (defined) RX_LOCKED=0 until next frame edge.
REQ-032 Per-bit walking-one across all 72 bit positions -> each appears only at its REQ-011 bit of DATA_OUT_TO_DEVICE.
